// File: rtl/pkt_stats_mon.sv
// pkt_stats_mon
//   Pass-through monitor placed after the IDS stage. Words enter a 2-entry
//   FIFO and leave unchanged. A framing FSM watches the departing words and
//   keeps wrapping packet / byte / framing-error counters.
//
// Handshake semantics (both sides):
//   Ingress: a word is accepted on a rising edge where in_wr && in_rdy.
//            in_wr while in_rdy is low drops the word and sets ovf_err.
//   Egress:  out_wr is high when the FIFO holds a word and out_rdy is high;
//            the head word departs on every such cycle.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   in_data/in_ctrl/in_wr  upstream word, ctrl and write strobe
//   in_rdy                 registered: FIFO has a free entry
//   out_data/out_ctrl      head entry, zero when the FIFO is empty
//   out_wr, out_rdy        egress strobe and downstream ready
//   stats_clr              synchronous clear of counters and ovf_err
//   pkt_cnt/byte_cnt/err_cnt  32-bit wrapping statistics
//   ovf_err                sticky ingress overflow flag
//   in_pkt                 framing FSM is mid-packet
//
// Build option: define PKT_STATS_BYTE_COUNT_EN to build byte accumulation;
// otherwise byte_cnt is tied to zero.
module pkt_stats_mon #(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter int MAX_PKT_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  stats_clr,
  output logic [31:0]           pkt_cnt,
  output logic [31:0]           byte_cnt,
  output logic [31:0]           err_cnt,
  output logic                  ovf_err,
  output logic                  in_pkt
);

  localparam int EW = CTRL_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MODHDR, S_BODY} state_t;

  // ---------------- FIFO ----------------
  logic [EW-1:0] mem_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    occ_q, occ_d;
  logic          in_rdy_q;
  logic          wr_en, rd_en;
  logic [EW-1:0] head;

  assign wr_en  = in_wr && in_rdy_q;
  assign rd_en  = out_wr;
  assign head   = mem_q[rd_ptr_q];
  assign out_wr = (occ_q != 2'd0) && out_rdy;
  assign {out_ctrl, out_data} = (occ_q != 2'd0) ? head : '0;
  assign in_rdy = in_rdy_q;

  always_comb begin
    occ_d = occ_q;
    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      in_rdy_q <= 1'b0;
    end else begin
      occ_q    <= occ_d;
      in_rdy_q <= (occ_d < 2'd2);
      if (wr_en) wr_ptr_q <= ~wr_ptr_q;
      if (rd_en) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {in_ctrl, in_data};
  end

  // ---------------- framing FSM ----------------
  state_t      state_q, state_d;
  logic [15:0] idx_q, idx_d, idx_inc;
  logic        pkt_inc, err_inc;
  logic        ctrl_nz, ctrl_onehot, is_last;

  assign ctrl_nz     = (out_ctrl != '0);
  assign ctrl_onehot = ctrl_nz &&
                       ((out_ctrl & (out_ctrl - {{(CTRL_WIDTH-1){1'b0}}, 1'b1})) == '0);
  assign is_last     = (state_q == S_BODY) && ctrl_nz;
  assign idx_inc     = (idx_q == 16'hFFFF) ? idx_q : idx_q + 16'd1;
  assign in_pkt      = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pkt_inc = 1'b0;
    err_inc = 1'b0;
    if (out_wr) begin
      case (state_q)
        S_IDLE: begin
          if (ctrl_nz) begin
            state_d = S_MODHDR;
            idx_d   = 16'd1;
          end else begin
            err_inc = 1'b1;            // stray word outside a packet
          end
        end
        S_MODHDR: begin
          idx_d = idx_inc;
          if (!ctrl_nz) state_d = S_BODY;
        end
        S_BODY: begin
          if (!ctrl_nz) begin
            idx_d = idx_inc;
          end else begin
            pkt_inc = 1'b1;
            state_d = S_IDLE;
            if (!ctrl_onehot) err_inc = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
      // A non-last word reaching the length limit aborts the packet. Stray
      // and last words never get here, so one word raises one error at most.
      if ((state_q != S_IDLE) && !is_last &&
          ({16'd0, idx_inc} >= 32'(MAX_PKT_WORDS))) begin
        err_inc = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // ---------------- statistics ----------------
  logic [31:0] pkt_q, err_q;
  logic        ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_q <= 32'd0;
      err_q <= 32'd0;
      ovf_q <= 1'b0;
    end else if (stats_clr) begin
      pkt_q <= 32'd0;
      err_q <= 32'd0;
      ovf_q <= 1'b0;
    end else begin
      if (pkt_inc) pkt_q <= pkt_q + 32'd1;
      if (err_inc) err_q <= err_q + 32'd1;
      if (in_wr && !in_rdy_q) ovf_q <= 1'b1;
    end
  end

  assign pkt_cnt = pkt_q;
  assign err_cnt = err_q;
  assign ovf_err = ovf_q;

`ifdef PKT_STATS_BYTE_COUNT_EN
  logic [31:0] byte_q, byte_add, last_bytes;

  // Last-word bytes = CTRL_WIDTH - index of the set bit; malformed ctrl
  // counts as a full word.
  always_comb begin
    last_bytes = 32'(CTRL_WIDTH);
    if (ctrl_onehot) begin
      for (int i = 0; i < CTRL_WIDTH; i++) begin
        if (out_ctrl[i]) last_bytes = 32'(CTRL_WIDTH - i);
      end
    end
  end

  always_comb begin
    byte_add = 32'd0;
    if (out_wr) begin
      if ((state_q != S_IDLE) && !ctrl_nz) byte_add = 32'(CTRL_WIDTH);
      else if (is_last)                    byte_add = last_bytes;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          byte_q <= 32'd0;
    else if (stats_clr) byte_q <= 32'd0;
    else                byte_q <= byte_q + byte_add;
  end

  assign byte_cnt = byte_q;
`else
  assign byte_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pkt_stats_mon.sv
// Directed bench for pkt_stats_mon (MAX_PKT_WORDS = 8). Inputs change #1
// after each rising edge; outputs are checked there as well.
module tb_pkt_stats_mon;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b1;
  logic        stats_clr = 1'b0;
  logic [31:0] pkt_cnt, byte_cnt, err_cnt;
  logic        ovf_err, in_pkt;

  int n_total = 0;
  int n_bad   = 0;

  pkt_stats_mon #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .MAX_PKT_WORDS(8)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .stats_clr(stats_clr), .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt),
    .err_cnt(err_cnt), .ovf_err(ovf_err), .in_pkt(in_pkt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected byte count depends on whether byte accumulation is built.
  function automatic logic [63:0] eb(input int b);
`ifdef PKT_STATS_BYTE_COUNT_EN
    return 64'(b);
`else
    return 64'd0 + 64'(b * 0);
`endif
  endfunction

  task automatic drive(input logic w, input logic [63:0] d, input logic [7:0] c);
    in_wr   = w;
    in_data = d;
    in_ctrl = c;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    stats_clr = 1'b1;
    drive(1'b0, 64'd0, 8'h00);
    stats_clr = 1'b0;
  endtask

  logic [63:0] p1_d [5];
  logic [7:0]  p1_c [5];

  initial begin
    p1_d[0] = 64'hAAAA_0000_0000_0001; p1_c[0] = 8'hFF;
    p1_d[1] = 64'h1111_2222_3333_4444; p1_c[1] = 8'h00;
    p1_d[2] = 64'h5555_6666_7777_8888; p1_c[2] = 8'h00;
    p1_d[3] = 64'h9999_AAAA_BBBB_CCCC; p1_c[3] = 8'h00;
    p1_d[4] = 64'hDEAD_BEEF_CAFE_F00D; p1_c[4] = 8'h10;

    // ---- reset ----
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_out_wr", out_wr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_pkt", pkt_cnt, 0);
    chk("rst_byte", byte_cnt, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_in_pkt", in_pkt, 0);

    // ---- basic packet, 1-cycle latency ----
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, p1_d[i], p1_c[i]);
      chk("p1_out_wr", out_wr, 1);
      chk("p1_out_data", out_data, p1_d[i]);
      chk("p1_out_ctrl", out_ctrl, p1_c[i]);
    end
    drive(1'b0, 64'd0, 8'h00);
    chk("p1_pkt", pkt_cnt, 1);
    chk("p1_byte", byte_cnt, eb(28));
    chk("p1_err", err_cnt, 0);
    chk("p1_in_pkt", in_pkt, 0);
    chk("p1_empty", out_wr, 0);

    // ---- backpressure and overflow ----
    out_rdy = 1'b0;
    drive(1'b1, 64'hA0A0, 8'hFF);
    chk("bp_rdy1", in_rdy, 1);
    drive(1'b1, 64'hB0B0, 8'h00);
    chk("bp_rdy2", in_rdy, 0);
    chk("bp_hold", out_wr, 0);
    drive(1'b1, 64'hC0C0, 8'h00);
    chk("bp_ovf", ovf_err, 1);
    in_wr   = 1'b0;
    out_rdy = 1'b1;
    #1;
    chk("bp_drain_wr", out_wr, 1);
    chk("bp_drain_a", out_data, 64'hA0A0);
    @(posedge clk); #1;
    chk("bp_drain_b", out_data, 64'hB0B0);
    chk("bp_rdy_back", in_rdy, 1);
    @(posedge clk); #1;
    chk("bp_drained", out_wr, 0);
    chk("bp_in_pkt", in_pkt, 1);
    drive(1'b1, 64'hD0D0, 8'h80);
    drive(1'b0, 64'd0, 8'h00);
    chk("bp_pkt", pkt_cnt, 2);
    chk("bp_byte", byte_cnt, eb(37));
    chk("bp_err", err_cnt, 0);

    // ---- clear, then stray word + packet ----
    clear_stats();
    chk("clr_pkt", pkt_cnt, 0);
    chk("clr_byte", byte_cnt, 0);
    chk("clr_ovf", ovf_err, 0);
    drive(1'b1, 64'h5757, 8'h00);
    drive(1'b1, 64'h1, 8'hFF);
    drive(1'b1, 64'h2, 8'h00);
    drive(1'b1, 64'h3, 8'h01);
    drive(1'b0, 64'd0, 8'h00);
    chk("stray_err", err_cnt, 1);
    chk("stray_pkt", pkt_cnt, 1);
    chk("stray_byte", byte_cnt, eb(16));

    // ---- overlength: 10 words, no last word ----
    clear_stats();
    drive(1'b1, 64'h100, 8'hFF);
    for (int i = 0; i < 9; i++) drive(1'b1, 64'h101 + 64'(i), 8'h00);
    drive(1'b0, 64'd0, 8'h00);
    chk("ovl_err", err_cnt, 3);
    chk("ovl_pkt", pkt_cnt, 0);
    chk("ovl_in_pkt", in_pkt, 0);

    // ---- exactly MAX_PKT_WORDS words with last word is legal ----
    clear_stats();
    drive(1'b1, 64'h200, 8'hFF);
    for (int i = 0; i < 6; i++) drive(1'b1, 64'h201 + 64'(i), 8'h00);
    drive(1'b1, 64'h2FF, 8'h01);
    drive(1'b0, 64'd0, 8'h00);
    chk("max_pkt", pkt_cnt, 1);
    chk("max_err", err_cnt, 0);
    chk("max_byte", byte_cnt, eb(56));

    // ---- non-one-hot last ctrl ----
    clear_stats();
    drive(1'b1, 64'h300, 8'hFF);
    drive(1'b1, 64'h301, 8'h00);
    drive(1'b1, 64'h302, 8'h11);
    drive(1'b0, 64'd0, 8'h00);
    chk("nh_err", err_cnt, 1);
    chk("nh_pkt", pkt_cnt, 1);
    chk("nh_byte", byte_cnt, eb(16));

    // ---- stats_clr on the cycle the last word departs ----
    drive(1'b1, 64'h400, 8'hFF);
    drive(1'b1, 64'h401, 8'h00);
    drive(1'b1, 64'h402, 8'h40);
    stats_clr = 1'b1;
    chk("sc_last_out", out_wr, 1);
    drive(1'b0, 64'd0, 8'h00);
    stats_clr = 1'b0;
    chk("sc_pkt", pkt_cnt, 0);
    chk("sc_byte", byte_cnt, 0);
    chk("sc_err", err_cnt, 0);
    chk("sc_in_pkt", in_pkt, 0);

    // ---- reset mid-packet ----
    drive(1'b1, 64'h500, 8'hFF);
    drive(1'b1, 64'h501, 8'h00);
    out_rdy = 1'b0;
    drive(1'b1, 64'h502, 8'h00);
    in_wr = 1'b0;
    chk("mr_in_pkt", in_pkt, 1);
    reset = 1'b1;
    #1;
    chk("mr_fsm_idle", in_pkt, 0);
    chk("mr_fifo_empty", out_data, 0);
    @(posedge clk); #1;
    reset   = 1'b0;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    chk("mr_in_rdy", in_rdy, 1);
    chk("mr_out_wr", out_wr, 0);
    chk("mr_pkt", pkt_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles long.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
